shape_rx: RTL
=============

# shape_rx

Receive-side counterpart to the `shape` transmit pulse shaper. The block takes the shaped I/Q sample stream (one sample per clock, 16 samples per symbol) and runs an integrate-and-dump matched filter per channel. It acquires symbol alignment from the first above-threshold sample and emits one averaged symbol value plus a sign decision per channel, once per symbol period. It drops lock after a run of empty symbols.

## Interface
- `SPS`, default 16: samples per symbol; must be a power of two ≥ 2.
- `THRESH`, default 32'd16384: acquisition threshold on the magnitude of a single sample.
- `LOSS_SYMS`, default 8: consecutive weak symbols before lock is dropped.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `xin` in 32: I sample, two's-complement signed.
- `yin` in 32: Q sample, two's-complement signed.
- `xout` out 32: I symbol value, accumulated sum arithmetic-shifted right by log2(SPS).
- `yout` out 32: Q symbol value, same scaling.
- `xbit` out 1: sign of `xout` (1 = negative).
- `ybit` out 1: sign of `yout` (1 = negative).
- `valid` out 1: one-cycle strobe; outputs are new this cycle.
- `locked` out 1: high while in TRACK.

## Operation
- **States:** ACQ, TRACK.
- **Reset:** state ACQ. `xout`/`yout` = 0, `xbit`/`ybit`/`valid`/`locked` = 0. Accumulators, sample counter and weak-symbol counter all 0.
- **Sample magnitude:** |s| is computed in 33 bits, so |−2^31| = 2^31 with no overflow.
- **ACQ:**
  - Condition: |xin| ≥ THRESH or |yin| ≥ THRESH.
  - When the condition holds on an edge, that sample becomes sample 0: acc_x/acc_y are loaded with it, the counter goes to 1, and the state moves to TRACK.
  - Otherwise the accumulators hold 0.
- **TRACK, counter 1..SPS-2:** acc += sample; counter increments.
- **TRACK, counter SPS-1:**
  - sum = acc + sample.
  - `xout`/`yout` ← sum >>> log2(SPS), arithmetic shift (floor division).
  - `xbit`/`ybit` ← output sign bit; `valid` ← 1.
  - acc ← 0; counter ← 0.
- **TRACK, counter 0:** acc ← sample; counter ← 1. There is no threshold test, because the alignment is already fixed.
- **Accumulator width:** 32 + log2(SPS) bits, sign-extended on add. No saturation; the shifted result always fits in 32 bits.
- **Weak symbol:**
  - Definition: |xout_next| < THRESH>>log2(SPS) and |yout_next| < THRESH>>log2(SPS).
  - A weak symbol increments the weak counter; any strong symbol clears it.
  - When the counter reaches LOSS_SYMS, at that same dump edge: state ← ACQ, `locked` ← 0, weak counter ← 0. The symbol is still output with `valid` = 1.
- **First cycle back in ACQ:** the threshold is tested on that cycle's sample. Re-acquisition is immediate if that sample is above threshold.
- **Held outputs:** `xout`/`yout`/`xbit`/`ybit` hold between strobes and are not cleared on lock loss.

## Timing
- **Acquisition latency:** for a trigger sample captured at edge t, `locked` = 1 from edge t onward.
- **Symbol output latency:** the 16th sample is captured at edge t+SPS−1, and `valid` is high for the single cycle after that edge, with the outputs updated.
- **Symbol period:** strobes are exactly SPS cycles apart while locked.
- **Asynchronous reset:** `rst` asserted at any point, including mid-symbol, forces the reset values immediately. Partial sums are discarded.
- **After reset release:** first acquisition is possible on the first rising edge with `rst` low.
- **No back-pressure:** the downstream consumer must take each strobe.

## Structure
- **Package `shape_pkg`:** holds SAMPLE_W = 32, the default SPS, ACC_W = SAMPLE_W + $clog2(SPS), and the state enum {ACQ, TRACK}. This is shared with `shape` so both ends agree on SPS and width.
- **Sub-module `shape_rx_acc`:**
  - One instance per channel, two in total.
  - Inputs: load, add, dump strobes. Outputs: scaled symbol and its magnitude.
  - `shape_rx` owns the FSM, the sample counter and the weak-symbol counter.

## Test plan
- **Positive impulse, default parameters:** xin = 46341 for one cycle then zeros, yin = 0 → `locked` rises; 16 cycles later `valid` = 1 with xout = 2896, xbit = 0, yout = 0.
- **Negative impulse:** xin = −46341 with the same pattern → xout = −2897, xbit = 1. Repeating impulses every 16 cycles give `valid` every 16 cycles with no drift.
- **Lock loss:** after lock, drive all zeros → 8 strobes with xout = 0, `locked` falls at the 8th dump edge, and a following 46351 impulse re-acquires: next xout = 2896.
- **Sub-threshold input:** xin = 16383 on every cycle, yin = 0 → never locks and `valid` never pulses. Changing to 16384 → locks on the first such sample.
- **Extreme values:** xin = 32'h80000000 for 16 cycles → locks and xout = 32'h80000000. Then 32'h7FFFFFFF for 16 cycles → xout = 32'h7FFFFFFF. No wrap in either case.
- **Reset mid-symbol:** assert `rst` at sample 7 of a symbol → outputs go to zero at once and `locked` = 0. After release, a new impulse gives the first `valid` exactly 16 cycles later with only the new data in the result.

Source files
------------

// File: rtl/shape_pkg.sv
// Shared constants and types for the shape transmit/receive pair.
// Both ends import this so sample width, SPS and state encoding stay in step.
package shape_pkg;

    localparam int unsigned SAMPLE_W    = 32;
    localparam int unsigned SPS_DEFAULT = 16;
    localparam int unsigned ACC_W       = SAMPLE_W + $clog2(SPS_DEFAULT);

    typedef enum logic {
        ACQ,
        TRACK
    } state_t;

    // One bit wider than the sample so that |-2^31| = 2^31 is representable.
    function automatic logic [SAMPLE_W:0] mag(input logic [SAMPLE_W-1:0] v);
        logic [SAMPLE_W:0] e;
        e = {v[SAMPLE_W-1], v};
        return e[SAMPLE_W] ? (~e + {{SAMPLE_W{1'b0}}, 1'b1}) : e;
    endfunction

endpackage

// File: rtl/shape_rx_if.sv
// Sample-in / symbol-out bundle for shape_rx.
// master drives the samples and consumes symbols; slave is the receiver.
interface shape_rx_if;
    import shape_pkg::*;

    logic [SAMPLE_W-1:0] xin;
    logic [SAMPLE_W-1:0] yin;
    logic [SAMPLE_W-1:0] xout;
    logic [SAMPLE_W-1:0] yout;
    logic                xbit;
    logic                ybit;
    logic                valid;
    logic                locked;

    modport master (
        output xin, yin,
        input  xout, yout, xbit, ybit, valid, locked
    );

    modport slave (
        input  xin, yin,
        output xout, yout, xbit, ybit, valid, locked
    );

endinterface

// File: rtl/shape_rx_acc.sv
// Integrate-and-dump accumulator for one channel.
// sym_mag is the magnitude of the symbol that a dump on this cycle would produce.
module shape_rx_acc
    import shape_pkg::*;
#(
    parameter int unsigned SPS = SPS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                load,
    input  logic                add,
    input  logic                dump,
    output logic [SAMPLE_W-1:0] sym,
    output logic [SAMPLE_W:0]   sym_mag
);

    localparam int unsigned SHIFT = $clog2(SPS);
    localparam int unsigned AW    = SAMPLE_W + SHIFT;

    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [AW-1:0]  sample_ext;
    logic signed [AW-1:0]  sum;
    logic [SAMPLE_W-1:0]   sym_next;

    always_comb begin
        sample_ext = {{SHIFT{sample[SAMPLE_W-1]}}, sample};
        sum        = acc_q + sample_ext;
        // Arithmetic shift floors toward -inf; the result always fits SAMPLE_W.
        sym_next   = SAMPLE_W'(sum >>> SHIFT);
        sym_mag    = mag(sym_next);
    end

    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = sample_ext;
        end else if (add) begin
            acc_d = sum;
        end else if (dump) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sym   <= '0;
        end else begin
            acc_q <= acc_d;
            if (dump) begin
                sym <= sym_next;
            end
        end
    end

endmodule

// File: rtl/shape_rx.sv
// Matched-filter receiver for the shape pulse shaper: acquires symbol timing from the
// first strong sample, dumps one averaged I/Q symbol per SPS samples, drops lock when idle.
module shape_rx
    import shape_pkg::*;
#(
    parameter int unsigned        SPS       = SPS_DEFAULT,
    parameter logic [SAMPLE_W-1:0] THRESH   = 32'd16384,
    parameter int unsigned        LOSS_SYMS = 8
) (
    input  logic       clk,
    input  logic       rst,
    shape_rx_if.slave  bus
);

    localparam int unsigned CW = $clog2(SPS);
    localparam int unsigned WW = $clog2(LOSS_SYMS + 1);

    localparam logic [CW-1:0]     LAST      = CW'(SPS - 1);
    localparam logic [WW-1:0]     WEAK_LAST = WW'(LOSS_SYMS - 1);
    localparam logic [SAMPLE_W:0] ACQ_THR   = {1'b0, THRESH};
    localparam logic [SAMPLE_W:0] WEAK_THR  = {1'b0, THRESH >> CW};

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   weak_q, weak_d;
    logic            valid_q, valid_d;
    logic            load, add, dump;
    logic            trig, weak_sym;
    logic [SAMPLE_W:0] x_sym_mag, y_sym_mag;

    shape_rx_acc #(.SPS(SPS)) u_acc_x (
        .clk     (clk),
        .rst     (rst),
        .sample  (bus.xin),
        .load    (load),
        .add     (add),
        .dump    (dump),
        .sym     (bus.xout),
        .sym_mag (x_sym_mag)
    );

    shape_rx_acc #(.SPS(SPS)) u_acc_y (
        .clk     (clk),
        .rst     (rst),
        .sample  (bus.yin),
        .load    (load),
        .add     (add),
        .dump    (dump),
        .sym     (bus.yout),
        .sym_mag (y_sym_mag)
    );

    assign trig     = (mag(bus.xin) >= ACQ_THR) || (mag(bus.yin) >= ACQ_THR);
    assign weak_sym = (x_sym_mag < WEAK_THR) && (y_sym_mag < WEAK_THR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACQ;
            cnt_q   <= '0;
            weak_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            weak_q  <= weak_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        weak_d  = weak_q;
        valid_d = 1'b0;
        load    = 1'b0;
        add     = 1'b0;
        dump    = 1'b0;
        unique case (state_q)
            ACQ: begin
                if (trig) begin
                    load    = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (cnt_q == LAST) begin
                    dump    = 1'b1;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    if (!weak_sym) begin
                        weak_d = '0;
                    end else if (weak_q == WEAK_LAST) begin
                        // The symbol is still emitted; lock drops on this same edge.
                        weak_d  = '0;
                        state_d = ACQ;
                    end else begin
                        weak_d = weak_q + WW'(1);
                    end
                end else if (cnt_q == '0) begin
                    load  = 1'b1;
                    cnt_d = CW'(1);
                end else begin
                    add   = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ACQ;
        endcase
    end

    always_comb begin
        bus.locked = (state_q == TRACK);
        bus.valid  = valid_q;
        bus.xbit   = bus.xout[SAMPLE_W-1];
        bus.ybit   = bus.yout[SAMPLE_W-1];
    end

endmodule
